debug_prf_access_ctrl: RTL and testbench

//  Initiator for the physical register file debug port (byte-wide addr/wrData/wrEn/rdData).

---
 rtl/debug_prf_access_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_debug_prf_access_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/debug_prf_access_ctrl.sv
// Debug initiator for the physical register file: splits full-word host reads/writes
// into NBYTES sequential byte accesses on the byte-wide PRF debug port.
module debug_prf_access_ctrl #(
   parameter int PHYS_LOG = 7,
   parameter int DATA_W   = 64,
   parameter int BYTE_W   = 8,
   parameter int OFF_W    = 3,
   parameter int RD_LAT   = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      req_write_i,
   input  logic [PHYS_LOG-1:0]       req_preg_i,
   input  logic [DATA_W-1:0]         req_wdata_i,
   output logic                      resp_valid_o,
   input  logic                      resp_ready_i,
   output logic [DATA_W-1:0]         resp_rdata_o,
   output logic [PHYS_LOG+OFF_W-1:0] debugPRFAddr_o,
   output logic [BYTE_W-1:0]         debugPRFWrData_o,
   output logic                      debugPRFWrEn_o,
   input  logic [BYTE_W-1:0]         debugPRFRdData_i
);

   localparam int NBYTES = 2 ** OFF_W;
   localparam int TP     = (RD_LAT > 0) ? RD_LAT : 1;
   localparam logic [OFF_W-1:0] K_LAST = OFF_W'(NBYTES - 1);
   localparam logic [OFF_W-1:0] K_ONE  = OFF_W'(1);
   localparam logic [2:0]       D_LAST = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t                      state_r, state_s;
   logic [OFF_W-1:0]            k_r, k_s;
   logic [2:0]                  dcnt_r, dcnt_s;
   logic [PHYS_LOG-1:0]         preg_r, preg_s;
   logic [DATA_W-1:0]           wdata_r, wdata_s;
   logic [DATA_W-1:0]           rbuf_r, rbuf_s, rbuf_next_s;
   logic [TP-1:0]               tag_v_r;
   logic [OFF_W-1:0]            tag_k_r [TP];
   logic                        issue_v_s;
   logic                        cap_v_s;
   logic [OFF_W-1:0]            cap_k_s;

   logic                        ready_r, ready_s;
   logic                        resp_valid_r, resp_valid_s;
   logic [DATA_W-1:0]           resp_rdata_r, resp_rdata_s;
   logic [PHYS_LOG+OFF_W-1:0]   addr_r, addr_s;
   logic [BYTE_W-1:0]           wrdata_r, wrdata_s;
   logic                        wren_r, wren_s;

   // Capture point: the byte whose address was on the port RD_LAT cycles ago
   always_comb begin
      issue_v_s = (state_r == READ);
      if (RD_LAT == 0) begin
         cap_v_s = issue_v_s;
         cap_k_s = k_r;
      end else begin
         cap_v_s = tag_v_r[TP-1];
         cap_k_s = tag_k_r[TP-1];
      end
      rbuf_s = rbuf_r;
      if (cap_v_s) begin
         rbuf_s[cap_k_s*BYTE_W +: BYTE_W] = debugPRFRdData_i;
      end else begin
         rbuf_s = rbuf_r;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_s      = state_r;
      k_s          = k_r;
      dcnt_s       = dcnt_r;
      preg_s       = preg_r;
      wdata_s      = wdata_r;
      rbuf_next_s  = rbuf_s;
      ready_s      = 1'b0;
      resp_valid_s = resp_valid_r;
      resp_rdata_s = resp_rdata_r;
      addr_s       = '0;
      wrdata_s     = '0;
      wren_s       = 1'b0;
      case (state_r)
         IDLE: begin
            ready_s      = 1'b1;
            resp_valid_s = 1'b0;
            resp_rdata_s = '0;
            if (req_valid_i && ready_r) begin
               ready_s     = 1'b0;
               preg_s      = req_preg_i;
               wdata_s     = req_wdata_i;
               k_s         = '0;
               rbuf_next_s = '0;
               addr_s      = {req_preg_i, {OFF_W{1'b0}}};
               if (req_write_i) begin
                  state_s  = WRITE;
                  wren_s   = 1'b1;
                  wrdata_s = req_wdata_i[BYTE_W-1:0];
               end else begin
                  state_s  = READ;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WRITE: begin
            if (k_r == K_LAST) begin
               state_s      = RESP;
               resp_valid_s = 1'b1;
               resp_rdata_s = '0;
            end else begin
               k_s      = k_r + K_ONE;
               addr_s   = {preg_r, k_s};
               wren_s   = 1'b1;
               wrdata_s = wdata_r[k_s*BYTE_W +: BYTE_W];
            end
         end
         READ: begin
            if (k_r == K_LAST) begin
               if (RD_LAT == 0) begin
                  state_s      = RESP;
                  resp_valid_s = 1'b1;
                  resp_rdata_s = rbuf_s;
               end else begin
                  state_s = DRAIN;
                  dcnt_s  = 3'd0;
               end
            end else begin
               k_s    = k_r + K_ONE;
               addr_s = {preg_r, k_s};
            end
         end
         DRAIN: begin
            if (dcnt_r == D_LAST) begin
               state_s      = RESP;
               resp_valid_s = 1'b1;
               resp_rdata_s = rbuf_s;
            end else begin
               dcnt_s = dcnt_r + 3'd1;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               state_s      = IDLE;
               resp_valid_s = 1'b0;
               resp_rdata_s = '0;
               ready_s      = 1'b1;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         k_r          <= '0;
         dcnt_r       <= 3'd0;
         preg_r       <= '0;
         wdata_r      <= '0;
         rbuf_r       <= '0;
         ready_r      <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= '0;
         addr_r       <= '0;
         wrdata_r     <= '0;
         wren_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         k_r          <= k_s;
         dcnt_r       <= dcnt_s;
         preg_r       <= preg_s;
         wdata_r      <= wdata_s;
         rbuf_r       <= rbuf_next_s;
         ready_r      <= ready_s;
         resp_valid_r <= resp_valid_s;
         resp_rdata_r <= resp_rdata_s;
         addr_r       <= addr_s;
         wrdata_r     <= wrdata_s;
         wren_r       <= wren_s;
      end
   end

   // Tag pipe: one entry per issued read byte, aged in step with the PRF read latency
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_v_r <= '0;
         for (int i = 0; i < TP; i++) begin
            tag_k_r[i] <= '0;
         end
      end else begin
         for (int i = TP - 1; i > 0; i--) begin
            tag_v_r[i] <= tag_v_r[i-1];
            tag_k_r[i] <= tag_k_r[i-1];
         end
         tag_v_r[0] <= issue_v_s;
         tag_k_r[0] <= k_r;
      end
   end

   assign req_ready_o      = ready_r;
   assign resp_valid_o     = resp_valid_r;
   assign resp_rdata_o     = resp_rdata_r;
   assign debugPRFAddr_o   = addr_r;
   assign debugPRFWrData_o = wrdata_r;
   assign debugPRFWrEn_o   = wren_r;

endmodule

// File: tb/tb_debug_prf_access_ctrl.sv
// Bench for debug_prf_access_ctrl: a byte-addressed PRF model with read latency,
// a word-level shadow register file as reference, directed cases then random traffic.
`timescale 1ns/1ps
module tb_debug_prf_access_ctrl;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready_o, req_write;
   logic [6:0]  req_preg;
   logic [63:0] req_wdata;
   logic        resp_valid_o, resp_ready;
   logic [63:0] resp_rdata_o;
   logic [9:0]  debugPRFAddr_o;
   logic [7:0]  debugPRFWrData_o;
   logic        debugPRFWrEn_o;
   logic [7:0]  prf_rd;

   always #5 clk = ~clk;

   debug_prf_access_ctrl #(.PHYS_LOG(7), .DATA_W(64), .BYTE_W(8), .OFF_W(3), .RD_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_write_i(req_write),
      .req_preg_i(req_preg), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata_o),
      .debugPRFAddr_o(debugPRFAddr_o), .debugPRFWrData_o(debugPRFWrData_o),
      .debugPRFWrEn_o(debugPRFWrEn_o), .debugPRFRdData_i(prf_rd)
   );

   // External PRF: byte array, data appears LAT cycles after the address
   logic [7:0]  prf [0:1023];
   logic [9:0]  addr_pipe [LAT];
   logic        prf_load;
   logic [63:0] ref_regs [0:127];

   assign prf_rd = prf[addr_pipe[LAT-1]];

   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) addr_pipe[i] <= addr_pipe[i-1];
      addr_pipe[0] <= debugPRFAddr_o;
      if (prf_load) begin
         for (int i = 0; i < 128; i++)
            for (int b = 0; b < 8; b++)
               prf[{i[6:0], b[2:0]}] <= ref_regs[i][8*b +: 8];
      end else if (debugPRFWrEn_o) begin
         prf[debugPRFAddr_o] <= debugPRFWrData_o;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request from a negedge and follow it through to the response handshake
   task automatic do_req(input logic wr, input logic [6:0] preg, input logic [63:0] wd,
                         input int hold, input logic keep_valid);
      int n;
      int lat;
      logic [63:0] exp_rd;
      req_write = wr;
      req_preg  = preg;
      req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      while (req_ready_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("req_ready_wait", 64'(n < 20), 64'd1);
      @(posedge clk);
      #1;
      req_preg  = 7'($urandom);
      req_wdata = {$urandom, $urandom};
      req_write = 1'($urandom);
      req_valid = keep_valid;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         check_val("addr", 64'(debugPRFAddr_o), 64'({preg, k[2:0]}));
         check_val("wren", 64'(debugPRFWrEn_o), 64'(wr));
         if (wr) check_val("wrdata", 64'(debugPRFWrData_o), 64'(wd[8*k +: 8]));
         check_val("ready_busy", 64'(req_ready_o), 64'd0);
         @(negedge clk);
      end
      check_val("wren_off", 64'(debugPRFWrEn_o), 64'd0);
      lat = 8;
      while (resp_valid_o !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_val("resp_latency", 64'(lat), wr ? 64'd8 : 64'(8 + LAT));
      exp_rd = wr ? 64'd0 : ref_regs[preg];
      check_val("resp_rdata", resp_rdata_o, exp_rd);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_val("hold_valid", 64'(resp_valid_o), 64'd1);
         check_val("hold_rdata", resp_rdata_o, exp_rd);
         check_val("hold_ready", 64'(req_ready_o), 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check_val("resp_done", 64'(resp_valid_o), 64'd0);
      check_val("ready_again", 64'(req_ready_o), 64'd1);
      if (wr) ref_regs[preg] = wd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [63:0] wd;
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_preg = 7'd0;
      req_wdata = 64'd0; resp_ready = 1'b0; prf_load = 1'b1;
      for (int i = 0; i < 128; i++) ref_regs[i] = {$urandom, $urandom};
      repeat (3) @(negedge clk);
      prf_load = 1'b0;
      check_val("rst_ready", 64'(req_ready_o), 64'd0);
      check_val("rst_resp_valid", 64'(resp_valid_o), 64'd0);
      check_val("rst_rdata", resp_rdata_o, 64'd0);
      check_val("rst_addr", 64'(debugPRFAddr_o), 64'd0);
      check_val("rst_wrdata", 64'(debugPRFWrData_o), 64'd0);
      check_val("rst_wren", 64'(debugPRFWrEn_o), 64'd0);
      reset = 1'b1;
      check_val("release_ready0", 64'(req_ready_o), 64'd0);
      @(negedge clk);
      check_val("release_ready1", 64'(req_ready_o), 64'd1);

      // Write then read preg 5, then backpressure with a stray request pending
      do_req(1'b1, 7'd5, 64'h0123456789ABCDEF, 0, 1'b0);
      do_req(1'b0, 7'd5, 64'd0, 0, 1'b0);
      do_req(1'b0, 7'd5, 64'd0, 5, 1'b1);
      do_req(1'b1, 7'd3, 64'hA5A5_0F0F_1234_8765, 2, 1'b0);

      // Reset in the middle of a write, while byte 3 is on the port
      wd = 64'hFEDC_BA98_7654_3210;
      req_write = 1'b1; req_preg = 7'd9; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      repeat (3) @(negedge clk);
      check_val("mid_addr", 64'(debugPRFAddr_o), 64'({7'd9, 3'd3}));
      check_val("mid_wren", 64'(debugPRFWrEn_o), 64'd1);
      reset = 1'b0;
      #1;
      check_val("arst_wren", 64'(debugPRFWrEn_o), 64'd0);
      check_val("arst_addr", 64'(debugPRFAddr_o), 64'd0);
      check_val("arst_wrdata", 64'(debugPRFWrData_o), 64'd0);
      check_val("arst_ready", 64'(req_ready_o), 64'd0);
      check_val("arst_resp_valid", 64'(resp_valid_o), 64'd0);
      ref_regs[9][23:0] = wd[23:0];
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check_val("rel2_ready0", 64'(req_ready_o), 64'd0);
      @(negedge clk);
      check_val("rel2_ready1", 64'(req_ready_o), 64'd1);
      do_req(1'b0, 7'd9, 64'd0, 0, 1'b0);

      // Back-to-back at the address extremes with valid held high
      do_req(1'b1, 7'd127, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
      do_req(1'b0, 7'd0, 64'd0, 0, 1'b1);
      do_req(1'b0, 7'd127, 64'd0, 1, 1'b0);

      for (int t = 0; t < 40; t++) begin
         logic [6:0] p;
         p = ($urandom_range(0, 9) == 0) ? 7'd127 : 7'($urandom_range(0, 7));
         do_req(1'($urandom_range(0, 1)), p, {$urandom, $urandom},
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      req_valid = 1'b0;
      for (int p = 0; p < 8; p++) do_req(1'b0, 7'(p), 64'd0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
